// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Receive-side checker for the parallel PRBS link-test generator. Each valid
// beat is compared against the word predicted from the previous beat, so the
// checker synchronises itself with no seed exchange. It reports lock, a
// per-beat error pulse, and saturating error and beat counters.
//
// Handshake: i_valid is a plain qualifier with no back-pressure. A beat is
// consumed on every rising clock edge where i_valid=1. Cycles with i_valid=0
// are gaps: nothing changes and they never count as errors.
//
// Ports
//   i_clock         sole clock
//   i_reset         asynchronous assert, active-high
//   i_word          received PRBS word (WIDTH bits)
//   i_valid         i_word is a new beat this cycle
//   i_clear_counts  synchronous clear of both counters (wins over a same-cycle beat)
//   o_locked        checker is in the LOCKED state
//   o_error         one-cycle pulse: mismatch on a beat while LOCKED
//   o_error_count   mismatches seen while LOCKED, saturating
//   o_beat_count    beats compared while LOCKED, saturating
//   o_dbg_state     raw FSM state (0 = HUNT, 1 = LOCKED)
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int WIDTH        = 128,
    parameter int TAP1         = 27,
    parameter int TAP2         = 30,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [WIDTH-1:0]       i_word,
    input  logic                   i_valid,
    input  logic                   i_clear_counts,
    output logic                   o_locked,
    output logic                   o_error,
    output logic [COUNT_WIDTH-1:0] o_error_count,
    output logic [COUNT_WIDTH-1:0] o_beat_count,
    output logic                   o_dbg_state
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    // The top bit of the previous word is shifted out of the prediction and
    // never feeds back (taps sit below it), so it is not stored.
    logic [WIDTH-2:0]       r_prev_word;
    logic                   r_have_prev;
    logic [MW-1:0]          r_match_run;
    logic [UW-1:0]          r_miss_run;
    logic                   r_error;
    logic [COUNT_WIDTH-1:0] r_error_count;
    logic [COUNT_WIDTH-1:0] r_beat_count;

    logic [WIDTH-1:0]       w_expected;
    logic                   w_compare;
    logic                   w_match;
    logic                   w_lock_hit;
    logic                   w_unlock_hit;
    logic [COUNT_WIDTH-1:0] w_error_inc;
    logic [COUNT_WIDTH-1:0] w_beat_inc;

    assign w_expected = {r_prev_word, r_prev_word[TAP1] ^ r_prev_word[TAP2]};
    assign w_compare  = i_valid && r_have_prev;
    // An all-zero word is a stuck line, never a valid PRBS word.
    assign w_match    = (i_word == w_expected) && (i_word != '0);

    // This beat completes the match run in HUNT / the miss run in LOCKED.
    assign w_lock_hit   = w_compare && w_match && (r_state == ST_HUNT) &&
                          (r_match_run == MW'(LOCK_COUNT - 1));
    assign w_unlock_hit = w_compare && !w_match && (r_state == ST_LOCKED) &&
                          (r_miss_run == UW'(UNLOCK_COUNT - 1));

    // Saturating increments: hold at all-ones instead of wrapping.
    assign w_error_inc = (r_error_count == '1) ? r_error_count
                                               : r_error_count + COUNT_WIDTH'(1);
    assign w_beat_inc  = (r_beat_count == '1)  ? r_beat_count
                                               : r_beat_count + COUNT_WIDTH'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_HUNT:   if (w_lock_hit)   w_next_state = ST_LOCKED;
            ST_LOCKED: if (w_unlock_hit) w_next_state = ST_HUNT;
            default:   w_next_state = ST_HUNT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_locked    = (r_state == ST_LOCKED);
        o_dbg_state = r_state;
    end

    // ---------------- Prediction history ----------------
    // Every valid beat replaces the history, match or not, so the very next
    // prediction is already resynchronised to the incoming stream.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_prev_word <= '0;
            r_have_prev <= 1'b0;
        end else if (i_valid) begin
            r_prev_word <= i_word[WIDTH-2:0];
            r_have_prev <= 1'b1;
        end
    end

    // ---------------- Run counters ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_match_run <= '0;
            r_miss_run  <= '0;
        end else if (w_compare) begin
            if (r_state == ST_HUNT) begin
                if (w_lock_hit) begin
                    r_match_run <= '0;
                    r_miss_run  <= '0;
                end else if (w_match) begin
                    r_match_run <= r_match_run + MW'(1);
                end else begin
                    r_match_run <= '0;
                end
            end else begin
                if (w_match) begin
                    r_miss_run <= '0;
                end else if (w_unlock_hit) begin
                    r_miss_run  <= '0;
                    r_match_run <= '0;
                end else begin
                    r_miss_run <= r_miss_run + UW'(1);
                end
            end
        end
    end

    // ---------------- Error pulse and statistics ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_error       <= 1'b0;
            r_error_count <= '0;
            r_beat_count  <= '0;
        end else begin
            r_error <= w_compare && (r_state == ST_LOCKED) && !w_match;
            // Clear has priority: a beat landing in the clear cycle is dropped
            // from the statistics.
            if (i_clear_counts) begin
                r_error_count <= '0;
                r_beat_count  <= '0;
            end else if (w_compare && (r_state == ST_LOCKED)) begin
                r_beat_count <= w_beat_inc;
                if (!w_match) begin
                    r_error_count <= w_error_inc;
                end
            end
        end
    end

    assign o_error       = r_error;
    assign o_error_count = r_error_count;
    assign o_beat_count  = r_beat_count;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  localparam int W      = 128;
  localparam int CW     = 32;
  localparam int CW_SAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] i_word = '0;
  logic         i_valid = 1'b0;
  logic         i_clear = 1'b0;

  logic          o_locked, o_error, o_dbg;
  logic [CW-1:0] o_errs, o_beats;
  logic              s_locked, s_error, s_dbg;
  logic [CW_SAT-1:0] s_errs, s_beats;

  prbs_checker #(.COUNT_WIDTH(CW)) dut (
    .i_clock(clk), .i_reset(rst), .i_word(i_word), .i_valid(i_valid),
    .i_clear_counts(i_clear), .o_locked(o_locked), .o_error(o_error),
    .o_error_count(o_errs), .o_beat_count(o_beats), .o_dbg_state(o_dbg)
  );

  // Narrow-counter copy fed the same stimulus to exercise saturation quickly.
  prbs_checker #(.COUNT_WIDTH(CW_SAT)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_word(i_word), .i_valid(i_valid),
    .i_clear_counts(i_clear), .o_locked(s_locked), .o_error(s_error),
    .o_error_count(s_errs), .o_beat_count(s_beats), .o_dbg_state(s_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Counts are kept unbounded and clipped only when compared.
  bit           m_have;
  logic [W-1:0] m_prev;
  bit           m_locked, m_err;
  int           m_match_run, m_miss_run;
  longint       m_errs, m_beats;

  function automatic logic [W-1:0] prbs_next(input logic [W-1:0] x);
    return {x[W-2:0], x[27] ^ x[30]};
  endfunction

  function automatic longint clip(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_have = 0; m_prev = '0; m_locked = 0; m_err = 0;
      m_match_run = 0; m_miss_run = 0; m_errs = 0; m_beats = 0;
    end else begin
      bit good;
      m_err = 0;
      if (i_valid) begin
        if (!m_have) begin
          m_have = 1;
        end else begin
          good = (i_word == prbs_next(m_prev)) && (i_word != '0);
          if (!m_locked) begin
            m_match_run = good ? m_match_run + 1 : 0;
            if (m_match_run == 16) begin
              m_locked = 1; m_match_run = 0; m_miss_run = 0;
            end
          end else begin
            m_beats++;
            if (good) m_miss_run = 0;
            else begin
              m_err = 1; m_errs++; m_miss_run++;
              if (m_miss_run == 8) begin
                m_locked = 0; m_match_run = 0; m_miss_run = 0;
              end
            end
          end
        end
        m_prev = i_word;
      end
      if (i_clear) begin
        m_errs = 0; m_beats = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("locked", 64'(o_locked), 64'(m_locked));
    check("error", 64'(o_error), 64'(m_err));
    check("error_count", 64'(o_errs), 64'(clip(m_errs, CW)));
    check("beat_count", 64'(o_beats), 64'(clip(m_beats, CW)));
    check("sat_locked", 64'(s_locked), 64'(m_locked));
    check("sat_error_count", 64'(s_errs), 64'(clip(m_errs, CW_SAT)));
    check("sat_beat_count", 64'(s_beats), 64'(clip(m_beats, CW_SAT)));
    if (o_error) err_pulses++;
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] src;

  task automatic drive(input logic v, input logic [W-1:0] w, input logic clr);
    i_valid = v; i_word = w; i_clear = clr;
    @(posedge clk); #1;
    i_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic src_beat();
    drive(1'b1, src, 1'b0);
    src = prbs_next(src);
  endtask

  task automatic bad_beat(input int bitn, input logic clr);
    logic [W-1:0] m;
    m = '0; m[bitn] = 1'b1;
    drive(1'b1, src ^ m, clr);
    src = prbs_next(src);
  endtask

  task automatic clear_counts();
    drive(1'b0, '0, 1'b1);
  endtask

  task automatic relock(input string tag);
    for (int i = 0; i < 16; i++) src_beat();
    check({tag, "_not_yet_locked"}, 64'(o_locked), 64'd0);
    src_beat();
    check({tag, "_locked_after_17"}, 64'(o_locked), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nvalid;
    src = {$urandom, $urandom, $urandom, $urandom};
    src[0] = 1'b1;  // keeps the low 31-bit LFSR core non-zero

    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", 64'(o_locked), 64'd0);
    check("reset_error_count", 64'(o_errs), 64'd0);
    check("reset_beat_count", 64'(o_beats), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: clean stream locks after 1 seed + 16 matches
    relock("t1");
    for (int i = 0; i < 10; i++) src_beat();
    check("t1_no_errors", 64'(o_errs), 64'd0);
    check("t1_beats", 64'(o_beats), 64'd10);

    // 2: one flipped bit gives two error pulses
    clear_counts();
    err_pulses = 0;
    bad_beat(5, 1'b0);
    for (int i = 0; i < 4; i++) src_beat();
    check("t2_err_pulses", 64'(err_pulses), 64'd2);
    check("t2_error_count", 64'(o_errs), 64'd2);
    check("t2_still_locked", 64'(o_locked), 64'd1);

    // 3: eight stuck-at-zero beats drop lock
    clear_counts();
    for (int i = 0; i < 7; i++) drive(1'b1, '0, 1'b0);
    check("t3_locked_after_7", 64'(o_locked), 64'd1);
    drive(1'b1, '0, 1'b0);
    check("t3_unlocked_after_8", 64'(o_locked), 64'd0);
    check("t3_error_count", 64'(o_errs), 64'd8);
    relock("t3");

    // 4: gaps with junk on the bus never count
    clear_counts();
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        src_beat(); nvalid++;
      end else begin
        drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      end
    end
    check("t4_beat_count", 64'(o_beats), 64'(nvalid));
    check("t4_error_count", 64'(o_errs), 64'd0);

    // 5: clear wins over a corrupted beat in the same cycle
    for (int i = 0; i < 3; i++) src_beat();
    bad_beat(9, 1'b1);
    check("t5_errs_cleared", 64'(o_errs), 64'd0);
    check("t5_beats_cleared", 64'(o_beats), 64'd0);
    src_beat();
    check("t5_next_errs", 64'(o_errs), 64'd1);
    check("t5_next_beats", 64'(o_beats), 64'd1);

    // randomized traffic: gaps, corruption, stuck words, clears
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 63);
      if (r < 16)       drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, r == 0);
      else if (r < 20)  bad_beat($urandom_range(0, W - 1), r == 19);
      else if (r == 20) drive(1'b1, '0, 1'b0);
      else if (r == 21) begin drive(1'b1, src, 1'b1); src = prbs_next(src); end
      else              src_beat();
    end

    // 6: asynchronous reset mid-lock, relock, then saturate the narrow counters
    for (int i = 0; i < 20; i++) src_beat();
    bad_beat(3, 1'b0);
    src_beat();
    #2 rst = 1'b1;
    #1;
    check("t6_async_locked", 64'(o_locked), 64'd0);
    check("t6_async_error", 64'(o_error), 64'd0);
    check("t6_async_errs", 64'(o_errs), 64'd0);
    check("t6_async_beats", 64'(o_beats), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    relock("t6");
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      bad_beat($urandom_range(0, 26), 1'b0);
      src_beat();
      src_beat();
    end
    check("t6_error_count", 64'(o_errs), 64'd20);
    check("t6_beat_count", 64'(o_beats), 64'd30);
    check("t6_sat_error_count", 64'(s_errs), 64'hF);
    check("t6_sat_beat_count", 64'(s_beats), 64'hF);
    check("t6_still_locked", 64'(o_locked), 64'd1);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
